// File: rtl/tc_mma_scheduler.sv
// Round-robin issue scheduler sharing one tensor-core MMA tile among NUM_REQ requesters.
// Grants one op at a time, drives the core handshake and returns tagged completions.
module tc_mma_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sched_en_i,
    input  logic [NUM_REQ-1:0]  req_valid_i,
    output logic [NUM_REQ-1:0]  req_grant_o,
    output logic [ID_W-1:0]     sel_idx_o,
    output logic                core_valid_o,
    output logic                core_enable_o,
    input  logic                core_ready_i,
    input  logic                core_result_valid_i,
    output logic                rsp_valid_o,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    output logic                err_sticky_o,
    output logic [15:0]         done_count_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam int unsigned SumW = ID_W + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] IdLast  = ID_W'(NUM_REQ - 1);
    localparam logic [SumW-1:0] NumReqW = SumW'(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e               state_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      sel_idx_q;
    logic [NUM_REQ-1:0]   req_grant_q;
    logic                 core_valid_q;
    logic                 core_enable_q;
    logic                 rsp_valid_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic                 rsp_err_q;
    logic                 busy_q;
    logic                 err_sticky_q;
    logic [15:0]          done_count_q;
    logic [CntW-1:0]      cnt_q;

    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    logic [ID_W-1:0]      ptr_next;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [SumW-1:0]      rr_sum;
    logic                 arbitrate;

    // First set request at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + SumW'(i);
            if (rr_sum >= NumReqW) begin
                rr_sum = rr_sum - NumReqW;
            end
            if (!win_found && req_valid_i[rr_sum[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        ptr_next            = (win_idx == IdLast) ? '0 : win_idx + 1'b1;
        arbitrate           = sched_en_i & core_ready_i & win_found;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            sel_idx_q     <= '0;
            req_grant_q   <= '0;
            core_valid_q  <= 1'b0;
            core_enable_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_sticky_q  <= 1'b0;
            done_count_q  <= '0;
            cnt_q         <= '0;
        end else begin
            req_grant_q <= '0;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A result with no op in flight is dropped but remembered.
                    if (core_result_valid_i) begin
                        err_sticky_q <= 1'b1;
                    end
                    if (arbitrate) begin
                        state_q       <= StIssue;
                        sel_idx_q     <= win_idx;
                        req_grant_q   <= win_onehot;
                        core_valid_q  <= 1'b1;
                        core_enable_q <= 1'b1;
                        rr_ptr_q      <= ptr_next;
                        busy_q        <= 1'b1;
                    end
                end
                StIssue: begin
                    if (core_result_valid_i) begin
                        err_sticky_q <= 1'b1;
                    end
                    core_valid_q  <= 1'b0;
                    core_enable_q <= 1'b0;
                    cnt_q         <= '0;
                    state_q       <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Result takes priority over a coincident timeout.
                    if (core_result_valid_i) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= sel_idx_q;
                        rsp_err_q    <= 1'b0;
                        done_count_q <= done_count_q + 16'd1;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end else if (cnt_q == CntLast) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= sel_idx_q;
                        rsp_err_q    <= 1'b1;
                        err_sticky_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_grant_o   = req_grant_q;
    assign sel_idx_o     = sel_idx_q;
    assign core_valid_o  = core_valid_q;
    assign core_enable_o = core_enable_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_err_o     = rsp_err_q;
    assign busy_o        = busy_q;
    assign err_sticky_o  = err_sticky_q;
    assign done_count_o  = done_count_q;

endmodule

// File: tb/tb_tc_mma_scheduler.sv
// Testbench for tc_mma_scheduler: directed scenarios plus a randomized run against
// a per-operation timing model of the scheduler and a latency-programmable core.
module tb_tc_mma_scheduler;

    localparam int NR = 4;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          sched_en_i = 1'b0;
    logic [NR-1:0] req_valid_i = '0;
    logic [NR-1:0] req_grant_o;
    logic [1:0]    sel_idx_o;
    logic          core_valid_o;
    logic          core_enable_o;
    logic          core_ready_i = 1'b1;
    logic          core_result_valid_i = 1'b0;
    logic          rsp_valid_o;
    logic [1:0]    rsp_id_o;
    logic          rsp_err_o;
    logic          busy_o;
    logic          err_sticky_o;
    logic [15:0]   done_count_o;

    int checks = 0;
    int errors = 0;
    int core_lat = 0;  // 0 means the core never answers
    int pend = 0;

    tc_mma_scheduler #(
        .NUM_REQ(NR),
        .ID_W   (2),
        .TIMEOUT(TO)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .sched_en_i         (sched_en_i),
        .req_valid_i        (req_valid_i),
        .req_grant_o        (req_grant_o),
        .sel_idx_o          (sel_idx_o),
        .core_valid_o       (core_valid_o),
        .core_enable_o      (core_enable_o),
        .core_ready_i       (core_ready_i),
        .core_result_valid_i(core_result_valid_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_id_o           (rsp_id_o),
        .rsp_err_o          (rsp_err_o),
        .busy_o             (busy_o),
        .err_sticky_o       (err_sticky_o),
        .done_count_o       (done_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to the next cycle; the core model raises its result core_lat cycles after accept.
    task automatic tick();
        @(posedge clk_i);
        #1;
        core_result_valid_i = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) core_result_valid_i = 1'b1;
        end
        if (core_valid_o && core_lat > 0) pend = core_lat;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        sched_en_i = 1'b0;
        req_valid_i = '0;
        core_ready_i = 1'b1;
        core_lat = 0;
        pend = 0;
        repeat (2) tick();
        rst_ni = 1'b1;
    endtask

    task automatic wait_rsp(input int max, output int n, output bit got);
        n = 0;
        got = 1'b0;
        while (!got && n < max) begin
            tick();
            n++;
            got = rsp_valid_o;
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst_ni = 1'b0;
        #3;
        checks++;
        if ({req_grant_o, sel_idx_o, core_valid_o, core_enable_o, rsp_valid_o, rsp_id_o,
             rsp_err_o, busy_o, err_sticky_o, done_count_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: got grant=%b sel=%0d cv=%b ce=%b rsp=%b id=%0d err=%b busy=%b stk=%b done=%0d, required all zero",
                     req_grant_o, sel_idx_o, core_valid_o, core_enable_o, rsp_valid_o, rsp_id_o,
                     rsp_err_o, busy_o, err_sticky_o, done_count_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_single_op();
        int n;
        bit got;
        do_reset();
        core_lat = 6;
        sched_en_i = 1'b1;
        req_valid_i = 4'b0100;
        tick();
        checks++;
        if (req_grant_o !== 4'b0100 || core_valid_o !== 1'b1 || core_enable_o !== 1'b1 ||
            sel_idx_o !== 2'd2 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got grant=%b cv=%b ce=%b sel=%0d busy=%b, required 0100 1 1 2 1",
                     req_grant_o, core_valid_o, core_enable_o, sel_idx_o, busy_o);
        end
        req_valid_i = '0;
        wait_rsp(20, n, got);
        checks++;
        if (!got || n != 7 || rsp_id_o !== 2'd2 || rsp_err_o !== 1'b0 || done_count_o !== 16'd1) begin
            errors++;
            $display("FAIL single_rsp: got seen=%b after=%0d id=%0d err=%b done=%0d, required 1 7 2 0 1",
                     got, n, rsp_id_o, rsp_err_o, done_count_o);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int idle_run;
        int max_idle;
        bit bad_onehot;
        do_reset();
        core_lat = 3;
        sched_en_i = 1'b1;
        req_valid_i = 4'b1111;
        idle_run = 0;
        max_idle = 0;
        bad_onehot = 1'b0;
        for (int c = 0; c < 100 && order.size() < 5; c++) begin
            tick();
            if (req_grant_o != '0) begin
                if ($countones(req_grant_o) != 1) bad_onehot = 1'b1;
                for (int k = 0; k < NR; k++) if (req_grant_o[k]) order.push_back(k);
            end
            if (busy_o) begin
                idle_run = 0;
            end else if (order.size() > 0) begin
                idle_run++;
                if (idle_run > max_idle) max_idle = idle_run;
            end
        end
        req_valid_i = '0;
        checks++;
        if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
            order[3] != 3 || order[4] != 0) begin
            errors++;
            $display("FAIL rr_order: got %p, required '{0,1,2,3,0}", order);
        end
        checks++;
        if (max_idle != 1 || bad_onehot) begin
            errors++;
            $display("FAIL rr_idle_gap: got max idle=%0d non-onehot=%b, required 1 0",
                     max_idle, bad_onehot);
        end
        wait_rsp(20, idle_run, bad_onehot);
    endtask

    task automatic test_timeout();
        int n;
        bit got;
        do_reset();
        core_lat = 0;
        sched_en_i = 1'b1;
        req_valid_i = 4'b0010;
        tick();
        checks++;
        if (req_grant_o !== 4'b0010) begin
            errors++;
            $display("FAIL to_grant: got %b, required 0010", req_grant_o);
        end
        req_valid_i = '0;
        wait_rsp(30, n, got);
        checks++;
        if (!got || n != TO + 1 || rsp_err_o !== 1'b1 || rsp_id_o !== 2'd1 ||
            err_sticky_o !== 1'b1 || done_count_o !== 16'd0) begin
            errors++;
            $display("FAIL to_abort: got seen=%b after=%0d err=%b id=%0d stk=%b done=%0d, required 1 %0d 1 1 1 0",
                     got, n, rsp_err_o, rsp_id_o, err_sticky_o, done_count_o, TO + 1);
        end
        core_lat = 4;
        req_valid_i = 4'b0001;
        tick();
        req_valid_i = '0;
        wait_rsp(30, n, got);
        checks++;
        if (!got || n != 5 || rsp_err_o !== 1'b0 || rsp_id_o !== 2'd0 ||
            done_count_o !== 16'd1 || err_sticky_o !== 1'b1) begin
            errors++;
            $display("FAIL to_recover: got seen=%b after=%0d err=%b id=%0d done=%0d stk=%b, required 1 5 0 0 1 1",
                     got, n, rsp_err_o, rsp_id_o, done_count_o, err_sticky_o);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        bit got;
        do_reset();
        core_lat = TO;
        sched_en_i = 1'b1;
        req_valid_i = 4'b1000;
        tick();
        req_valid_i = '0;
        wait_rsp(30, n, got);
        checks++;
        if (!got || n != TO + 1 || rsp_err_o !== 1'b0 || rsp_id_o !== 2'd3 ||
            done_count_o !== 16'd1 || err_sticky_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_result: got seen=%b after=%0d err=%b id=%0d done=%0d stk=%b, required 1 %0d 0 3 1 0",
                     got, n, rsp_err_o, rsp_id_o, done_count_o, err_sticky_o, TO + 1);
        end
    endtask

    task automatic test_enable_withdraw();
        int n;
        bit got;
        bit stray;
        do_reset();
        core_lat = 5;
        req_valid_i = 4'b0011;
        stray = 1'b0;
        repeat (4) begin
            tick();
            if (req_grant_o != '0 || busy_o) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL en_off_nogrant: got a grant or busy with sched_en=0, required none");
        end
        sched_en_i = 1'b1;
        tick();
        checks++;
        if (req_grant_o !== 4'b0001) begin
            errors++;
            $display("FAIL en_on_grant: got %b, required 0001", req_grant_o);
        end
        req_valid_i = 4'b0010;
        tick();
        sched_en_i = 1'b0;
        req_valid_i = 4'b1010;
        tick();
        req_valid_i = 4'b0010;
        stray = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = rsp_valid_o;
            if (req_grant_o != '0) stray = 1'b1;
        end
        checks++;
        if (!got || rsp_id_o !== 2'd0 || rsp_err_o !== 1'b0 || stray) begin
            errors++;
            $display("FAIL en_drop_completes: got seen=%b id=%0d err=%b stray=%b, required 1 0 0 0",
                     got, rsp_id_o, rsp_err_o, stray);
        end
        repeat (2) begin
            tick();
            if (req_grant_o != '0) stray = 1'b1;
        end
        sched_en_i = 1'b1;
        tick();
        checks++;
        if (req_grant_o !== 4'b0010 || stray) begin
            errors++;
            $display("FAIL withdraw_skip: got %b stray=%b, required 0010 0", req_grant_o, stray);
        end
        req_valid_i = '0;
        wait_rsp(20, n, got);
    endtask

    task automatic test_reset_midop();
        int n;
        bit got;
        bit stray;
        do_reset();
        core_lat = 2;
        sched_en_i = 1'b1;
        req_valid_i = 4'b0001;
        tick();
        req_valid_i = '0;
        wait_rsp(20, n, got);
        core_lat = 0;
        req_valid_i = 4'b1000;
        tick();
        req_valid_i = '0;
        repeat (3) tick();
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_grant_o, sel_idx_o, core_valid_o, core_enable_o, rsp_valid_o, rsp_id_o,
             rsp_err_o, busy_o, err_sticky_o, done_count_o} !== '0) begin
            errors++;
            $display("FAIL midop_reset: got grant=%b sel=%0d cv=%b rsp=%b id=%0d busy=%b stk=%b done=%0d, required all zero",
                     req_grant_o, sel_idx_o, core_valid_o, rsp_valid_o, rsp_id_o, busy_o,
                     err_sticky_o, done_count_o);
        end
        repeat (2) tick();
        rst_ni = 1'b1;
        stray = 1'b0;
        repeat (12) begin
            tick();
            if (rsp_valid_o || busy_o) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL midop_dropped: got rsp_valid or busy after reset, required none");
        end
    endtask

    task automatic test_spurious();
        do_reset();
        tick();
        core_result_valid_i = 1'b1;
        tick();
        checks++;
        if (err_sticky_o !== 1'b1 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0 ||
            done_count_o !== 16'd0) begin
            errors++;
            $display("FAIL spurious: got stk=%b rsp=%b busy=%b done=%0d, required 1 0 0 0",
                     err_sticky_o, rsp_valid_o, busy_o, done_count_o);
        end
    endtask

    // Each granted op is modelled as a whole: accept cycle a, response at a+1+min(lat,TO).
    task automatic test_random();
        int m_acc, m_rsp, m_owner, m_rr, lat, w, idx;
        bit m_err, m_sticky, e_cv, e_rsp, e_busy;
        logic [15:0] m_done;
        logic [NR-1:0] e_grant;
        do_reset();
        m_acc = 0;
        m_rsp = 0;
        m_owner = 0;
        m_rr = 0;
        m_err = 1'b0;
        m_sticky = 1'b0;
        m_done = '0;
        e_grant = '0;
        e_cv = 1'b0;
        e_rsp = 1'b0;
        e_busy = 1'b0;
        for (int c = 0; c < 600; c++) begin
            tick();
            checks++;
            if (req_grant_o !== e_grant || core_valid_o !== e_cv || rsp_valid_o !== e_rsp ||
                busy_o !== e_busy || done_count_o !== m_done || err_sticky_o !== m_sticky) begin
                errors++;
                $display("FAIL rand_c%0d: got grant=%b cv=%b rsp=%b busy=%b done=%0d stk=%b, required %b %b %b %b %0d %b",
                         c, req_grant_o, core_valid_o, rsp_valid_o, busy_o, done_count_o,
                         err_sticky_o, e_grant, e_cv, e_rsp, e_busy, m_done, m_sticky);
            end
            if (e_rsp) begin
                checks++;
                if (rsp_id_o !== 2'(m_owner) || rsp_err_o !== m_err) begin
                    errors++;
                    $display("FAIL rand_rsp_c%0d: got id=%0d err=%b, required %0d %b",
                             c, rsp_id_o, rsp_err_o, m_owner, m_err);
                end
            end
            req_valid_i = ($urandom_range(0, 2) == 0) ? '0 : 4'($urandom_range(0, 15));
            sched_en_i = ($urandom_range(0, 9) != 0);
            core_ready_i = ($urandom_range(0, 7) != 0);
            e_grant = '0;
            e_cv = 1'b0;
            e_rsp = 1'b0;
            if (!(c >= m_acc && c < m_rsp) && sched_en_i && core_ready_i && req_valid_i != '0) begin
                w = -1;
                for (int k = 0; k < NR; k++) begin
                    idx = (m_rr + k) % NR;
                    if (w < 0 && req_valid_i[idx]) w = idx;
                end
                lat = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TO));
                core_lat = lat;
                m_acc = c + 1;
                m_rsp = m_acc + 1 + ((lat == 0) ? TO : lat);
                m_err = (lat == 0);
                m_owner = w;
                m_rr = (w + 1) % NR;
                e_grant[w] = 1'b1;
                e_cv = 1'b1;
            end
            e_busy = (c + 1 >= m_acc) && (c + 1 < m_rsp);
            if (c + 1 == m_rsp) begin
                e_rsp = 1'b1;
                if (m_err) m_sticky = 1'b1;
                else m_done = m_done + 16'd1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_enable_withdraw();
        test_reset_midop();
        test_spurious();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_mma_scheduler.md
# tc_mma_scheduler

Round-robin issue scheduler that shares one `tensor_core_fp16_mma` tile among `NUM_REQ` requesters, such as warps or DMA fill engines. It grants one requester at a time and drives the core's valid/enable handshake. It steers the external operand mux through `sel_idx`, waits for `result_valid`, then returns a tagged completion to the owner. A timeout watchdog guards every in-flight operation.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..16).
- `ID_W`, default `$clog2(NUM_REQ)`: width of `sel_idx` and `rsp_id`.
- `TIMEOUT`, default 64: cycles allowed in WAIT before the op is aborted (must be ≥ 2).
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `sched_en`, input, 1: global enable; when 0 no new grants are issued.
- `req_valid`, input, NUM_REQ: level request per requester; held until granted, and may be withdrawn before grant.
- `req_grant`, output, NUM_REQ: one-hot, single-cycle pulse marking acceptance of a requester's op.
- `sel_idx`, output, ID_W: index of the current/last granted requester; drives the A/B/C operand mux.
- `core_valid`, output, 1: connects to core `mma_valid`.
- `core_enable`, output, 1: connects to core `mma_enable`.
- `core_ready`, input, 1: from core `mma_ready`.
- `core_result_valid`, input, 1: from core `result_valid`.
- `rsp_valid`, output, 1: single-cycle completion pulse.
- `rsp_id`, output, ID_W: requester owning the completion.
- `rsp_err`, output, 1: completion was a timeout abort (core `matrix_d` is not valid).
- `busy`, output, 1: state ≠ IDLE.
- `err_sticky`, output, 1: a timeout or spurious result has occurred; cleared only by reset.
- `done_count`, output, 16: count of successful completions; wraps at 0xFFFF → 0.

## Operation
- FSM states are IDLE, ISSUE and WAIT. All outputs are registered.
- **IDLE:** arbitration fires when `sched_en & core_ready & |req_valid`.
  - Winner w is the first set `req_valid` bit searching from `rr_ptr` upward, with wrap.
  - On the next edge: state → ISSUE, `sel_idx`=w, `req_grant[w]`=1, `core_valid`=`core_enable`=1, and `rr_ptr`=(w+1) mod NUM_REQ.
- **ISSUE:** lasts exactly one cycle. On the next edge: `core_valid`, `core_enable` and `req_grant` → 0, state → WAIT, and the timeout counter is cleared.
- **WAIT:** the counter increments each cycle.
  - If `core_result_valid`=1: on the next edge `rsp_valid`=1, `rsp_id`=`sel_idx`, `rsp_err`=0, `done_count`+1, state → IDLE.
  - Else, if the counter = TIMEOUT-1: on the next edge `rsp_valid`=1, `rsp_err`=1, `err_sticky`=1, state → IDLE.
  - If both conditions hold in the same cycle, the result wins (`rsp_err`=0).
- `sel_idx` holds its value until the next grant. The core latches its operands at acceptance, so the mux needs to be stable only during the ISSUE cycle.
- `core_result_valid`=1 while in IDLE or ISSUE is spurious: it is ignored, sets `err_sticky`, and produces no `rsp_valid`.
- `sched_en` falling while in ISSUE or WAIT does not stop the op; it runs to completion. Only new grants are suppressed.
- A `req_valid` bit that drops before its grant is simply not selected. A requester may re-request in the same cycle its `rsp_valid` is seen.
- `rr_ptr` advances only on a grant.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `sel_idx`=0, `req_grant`=0, `core_valid`=0, `core_enable`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_err`=0, `busy`=0, `err_sticky`=0, `done_count`=0.
- Request-to-grant: if a request is seen in IDLE at cycle t, `req_grant` and `core_valid` are high in cycle t+1. The core accepts at the end of t+1.
- Completion: `core_result_valid` high in cycle r gives `rsp_valid` in cycle r+1. At that point the core's `matrix_d` is still stable, because it holds until the next writeback.
- Back-to-back: arbitration may run in the same IDLE cycle where `rsp_valid`=1. The next grant therefore appears at r+2.
- Throughput: at most one op in flight, so the minimum period is 3 cycles plus core latency.
- Reset asserted mid-op: all state returns to reset values immediately. The in-flight op is dropped with no `rsp_valid`. The core shares `rst_n`.

## Test plan
- **Single op.** Setup: NUM_REQ=4, core model asserts result 6 cycles after accepting; `req_valid`=0b0100 at t=0. Expect: `req_grant`=0b0100 and `core_valid`=1 at t=1; `rsp_valid`=1 with `rsp_id`=2, `rsp_err`=0 at t=8; `done_count`=1.
- **Round-robin fairness.** Stimulus: `req_valid`=0b1111 held. Expect grants in the order 0,1,2,3,0; no requester is granted twice while others wait; `busy` never drops between ops except for single IDLE cycles.
- **Timeout.** Setup: TIMEOUT=8, core never responds, requester 1 requests. Expect: `rsp_valid`=1, `rsp_err`=1, `rsp_id`=1 exactly 8 cycles after entering WAIT; `err_sticky`=1; `done_count` unchanged. A following request to a responsive core then completes normally.
- **Simultaneous result and timeout.** Stimulus: result arrives in the same cycle the counter reaches TIMEOUT-1. Expect `rsp_err`=0 and `done_count` incremented.
- **Enable and withdraw.**
  - `sched_en`=0 with `req_valid`=0b0011: no grant.
  - `sched_en` raised: grant to 0.
  - `sched_en` dropped during WAIT: op still completes.
  - Requester 3 raises then drops `req_valid` while busy: it is never granted.
- **Reset and spurious result.**
  - `rst_n` pulsed low during WAIT: all outputs return to reset values with no `rsp_valid`.
  - Spurious `core_result_valid` in IDLE: `err_sticky`=1, no response.
